// File: rtl/load_store_unit.sv
// Load/store controller between the pipeline and a big-endian, word-wide data memory.
// Sub-word stores are read-modify-write; misaligned or illegal requests complete without a memory cycle.
module load_store_unit #(
    parameter int READ_WAIT = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        IsStore,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        AddressError,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEnable,
    output logic        MemoryRead,
    input  logic [31:0] MemData,
    output logic [1:0]  DebugState
);

    localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(READ_WAIT - 1);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    off_q, off_d;
    logic          store_q, store_d;
    logic [15:0]   sdata_q, sdata_d;
    logic          err_q, err_d;
    logic [31:0]   load_q, load_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, done_q, aerr_q, mwe_q, mrd_q;

    function automatic logic is_legal(input logic st, input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_B:    is_legal = 1'b1;
            OP_H:    is_legal = ~off[0];
            OP_W:    is_legal = (off == 2'b00);
            OP_BU:   is_legal = ~st;
            OP_HU:   is_legal = ~st & ~off[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

    // Lane 0 is the most significant byte (big-endian).
    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [2:0] op,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_B:    extend_load = {{24{b[7]}}, b};
            OP_BU:   extend_load = {24'd0, b};
            OP_H:    extend_load = {{16{h[15]}}, h};
            OP_HU:   extend_load = {16'd0, h};
            default: extend_load = w;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [2:0] op,
                                                input logic [1:0] off, input logic [15:0] s);
        merge_store = w;
        if (op == OP_B) begin
            case (off)
                2'd0:    merge_store[31:24] = s[7:0];
                2'd1:    merge_store[23:16] = s[7:0];
                2'd2:    merge_store[15:8]  = s[7:0];
                default: merge_store[7:0]   = s[7:0];
            endcase
        end else if (off[1]) begin
            merge_store[15:0] = s;
        end else begin
            merge_store[31:16] = s;
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        off_d   = off_q;
        store_d = store_q;
        sdata_d = sdata_q;
        err_d   = err_q;
        load_d  = load_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    off_d   = Addr[1:0];
                    store_d = IsStore;
                    sdata_d = StoreData[15:0];
                    cnt_d   = '0;
                    if (!is_legal(IsStore, Op, Addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        maddr_d = {Addr[31:2], 2'b00};
                        if (IsStore && (Op == OP_W)) begin
                            wdata_d = StoreData;
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WAIT) begin
                    // The write-data register doubles as the RMW holding register.
                    if (store_q) begin
                        wdata_d = merge_store(MemData, op_q, off_q, sdata_q);
                        state_d = S_WRITE;
                    end else begin
                        load_d  = extend_load(MemData, op_q, off_q);
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            off_q   <= '0;
            store_q <= 1'b0;
            sdata_q <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
            maddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            mwe_q   <= 1'b0;
            mrd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            off_q   <= off_d;
            store_q <= store_d;
            sdata_q <= sdata_d;
            err_q   <= err_d;
            load_q  <= load_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            // Strobes are flopped from the next state so they are glitch-free.
            busy_q  <= (state_d == S_READ) || (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
            aerr_q  <= (state_d == S_DONE) && err_d;
            mwe_q   <= (state_d == S_WRITE);
            mrd_q   <= (state_d == S_READ);
        end
    end

    assign Busy           = busy_q;
    assign Done           = done_q;
    assign LoadData       = load_q;
    assign AddressError   = aerr_q;
    assign MemAddress     = maddr_q;
    assign MemWriteData   = wdata_q;
    assign MemWriteEnable = mwe_q;
    assign MemoryRead     = mrd_q;
    assign DebugState     = state_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage access controller that sits between the processor pipeline and the byte-addressed, big-endian data memory. It takes one load or store request at a time and drives the memory's address, write-data, write-enable and read-enable lines. It sign- or zero-extends sub-word loads, and performs a read-modify-write to implement byte and halfword stores on a word-wide memory port. Misaligned requests are flagged without touching memory.

## Interface
- READ_WAIT, default 2: number of cycles MemoryRead is held before MemData is captured; must be at least 1 and must cover the memory's read-path delay.
- CLK  in  1  the single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; forces IDLE immediately.
- Start  in  1  request strobe; sampled only in IDLE.
- IsStore  in  1  1 = store, 0 = load.
- Op  in  3  access size, taken from the low 3 bits of the MIPS opcode:
  - 000 = byte (LB/SB), 001 = half (LH/SH), 011 = word (LW/SW);
  - for loads only: 100 = LBU, 101 = LHU;
  - all other codes are illegal.
- Addr  in  32  byte address of the request.
- StoreData  in  32  store value; the byte and halfword forms use its low bits.
- Busy  out  1  high in READ and WRITE.
- Done  out  1  single-cycle completion pulse.
- LoadData  out  32  extended load result.
- AddressError  out  1  misaligned or illegal request.
- MemAddress  out  32  word-aligned address: {Addr[31:2], 2'b00}.
- MemWriteData  out  32  merged word to be written.
- MemWriteEnable  out  1  memory write strobe.
- MemoryRead  out  1  memory read enable.
- MemData  in  32  memory read word; big-endian, so byte offset 0 is bits [31:24].

## Operation
- FSM states are IDLE, READ, WRITE and DONE.
- IDLE:
  - On Start=1, latch Addr, Op, IsStore and StoreData into request registers. Inputs are ignored after the latch.
  - If the request is illegal, go directly to DONE with AddressError=1 and no memory cycle. A request is illegal if any of these hold:
    - the Op code is illegal;
    - a halfword access has Addr[0]=1;
    - a word access has Addr[1:0]≠0;
    - a store uses Op 100 or 101.
- Legal requests go to the following state:
  - load, or byte/half store → READ;
  - word store → WRITE.
- READ:
  - MemoryRead=1 and MemAddress is driven.
  - A wait counter runs from 0 to READ_WAIT−1.
  - On the edge that ends the last READ cycle, MemData is captured into a holding register.
  - Then: load → DONE; store → WRITE.
- WRITE:
  - MemWriteEnable=1 for exactly one cycle, then → DONE.
  - Word store: MemWriteData = StoreData.
  - Byte store: the captured word with lane Addr[1:0] replaced by StoreData[7:0]. Lane 0 is [31:24] and lane 3 is [7:0].
  - Half store: offset 0 replaces [31:16] and offset 2 replaces [15:0], using StoreData[15:0].
- DONE: Done=1 for one cycle, then → IDLE.
- LoadData is updated on entry to DONE for legal loads only. It holds its value until the next legal load completes.
  - Selected byte or halfword follows the same lane mapping as stores.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- AddressError:
  - asserted only in the DONE cycle of an illegal request;
  - 0 otherwise.
- Start is ignored outside IDLE, including during the DONE cycle; no queuing.

## Timing
- Reset values:
  - state = IDLE;
  - Busy, Done, AddressError, MemWriteEnable, MemoryRead = 0;
  - LoadData, MemAddress, MemWriteData = 0.
- Reset mid-operation:
  - all outputs clear asynchronously;
  - an in-flight store is aborted with memory unchanged, unless the WRITE-ending edge had already occurred;
  - no Done pulse is produced for the aborted request.
- Latency, counted from the Start-sampling edge to the Done cycle, with W = READ_WAIT:
  - load: W+1 cycles;
  - word store: 2 cycles;
  - byte or half store: W+2 cycles;
  - illegal request: 1 cycle.
- Back-to-back requests: the earliest next Start is sampled in the IDLE cycle following DONE. Request throughput is therefore latency + 1 cycles.
- All memory-side outputs are registered.
  - MemWriteEnable and MemoryRead are never both 1.
  - Both are 0 in IDLE and DONE.
  - MemAddress and MemWriteData are stable for the whole time either strobe is high.

## Test plan
- Reset mid-operation: assert Reset during the WRITE cycle of SB at Addr 0x20 → MemWriteEnable drops immediately, no Done pulse follows, and a subsequent LW 0x20 reads back the original word unchanged.
- Word store then loads: SW StoreData=0x80FF_1234 at Addr 0x10, then each of the following loads → required LoadData, with Done timing matching the latencies above for W=2 and W=3:
  - LW 0x10 → 0x80FF_1234;
  - LB 0x10 → 0xFFFF_FF80;
  - LBU 0x10 → 0x0000_0080;
  - LH 0x12 → 0x0000_1234;
  - LHU 0x10 → 0x0000_80FF.
- Sub-word stores (memory word 0x1122_3344 at 0x20):
  - SB StoreData=0xAB at 0x21 → word 0x11AB_3344;
  - then SH StoreData=0xBEEF at 0x22 → word 0x11AB_BEEF;
  - exactly one MemWriteEnable pulse per store.
- Misaligned and illegal requests: each of the following → one-cycle Done with AddressError=1, MemoryRead and MemWriteEnable never asserted, and LoadData unchanged:
  - LW 0x13;
  - SH 0x21;
  - Op=010;
  - store with Op=100.
- Start held high continuously over four LW requests → one request accepted per W+2 cycles, and Start is ignored while Busy or Done is high.
